spi_regfile_periph: RTL and testbench

//  SPI mode-0 peripheral: generalised register file, clk-domain oversampled, with read-back on CIPO.

---
 rtl/spi_regfile_periph.sv | 162 ++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral register file, oversampled in the clk domain.
// Frame = R/W + address + data (MSB first); writes commit on nCS rise after a complete frame.
module spi_regfile_periph #(
    parameter int SYNC_FLOPS = 2,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ADDR = CNT_W'(ADDR_W);
    localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [SYNC_FLOPS-1:0]   r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [FRAME_W-1:0]      r_shift_in;
    logic [DATA_W-1:0]       r_shift_out;
    logic                    r_rd_active;
    logic                    r_cipo;
    logic                    r_wr_strobe;
    logic                    r_frame_err;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [DATA_W-1:0]       r_regs [NUM_REGS];

    logic                    w_sclk_rise, w_sclk_fall, w_ncs_low, w_ncs_rise, w_copi;
    logic [FRAME_W-1:0]      w_shift_nxt;
    logic                    w_start, w_in_frame, w_bit, w_rd_load, w_out;
    logic                    w_frame_ok, w_rw, w_addr_ok, w_commit_wr, w_commit_err;
    logic [ADDR_W-1:0]       w_addr, w_rd_addr;
    logic [DATA_W-1:0]       w_data, w_rd_data;

    // Input synchronisers; idle levels keep a reset peripheral out of any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_FLOPS-2:0], SCLK};
            r_copi_sync <= {r_copi_sync[SYNC_FLOPS-2:0], COPI};
            r_ncs_sync  <= {r_ncs_sync[SYNC_FLOPS-2:0], nCS};
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_FLOPS-2] & ~r_sclk_sync[SYNC_FLOPS-1];
    assign w_sclk_fall = ~r_sclk_sync[SYNC_FLOPS-2] & r_sclk_sync[SYNC_FLOPS-1];
    assign w_ncs_low   = ~r_ncs_sync[SYNC_FLOPS-2];
    assign w_ncs_rise  = r_ncs_sync[SYNC_FLOPS-2] & ~r_ncs_sync[SYNC_FLOPS-1];
    assign w_copi      = r_copi_sync[SYNC_FLOPS-2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Level-based start so a fall seen during COMMIT is picked up one cycle later.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_ncs_low)  w_state_nxt = ST_SHIFT;
            ST_SHIFT:  if (w_ncs_rise) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_shift_nxt = {r_shift_in[FRAME_W-2:0], w_copi};
    assign w_start     = (r_state == ST_IDLE) & w_ncs_low;
    // An nCS rise masks any SCLK edge in the same cycle.
    assign w_in_frame  = (r_state == ST_SHIFT) & ~w_ncs_rise;
    assign w_bit       = w_in_frame & w_sclk_rise;
    assign w_rd_addr   = w_shift_nxt[ADDR_W-1:0];
    assign w_rd_load   = w_bit & (r_bit_cnt == CNT_ADDR) & ~w_shift_nxt[ADDR_W];
    assign w_out       = w_in_frame & w_sclk_fall & r_rd_active;

    assign w_rw        = r_shift_in[FRAME_W-1];
    assign w_addr      = r_shift_in[FRAME_W-2 -: ADDR_W];
    assign w_data      = r_shift_in[DATA_W-1:0];
    assign w_frame_ok  = (r_bit_cnt == CNT_FULL);
    assign w_addr_ok   = ({1'b0, w_addr} < NREGS);
    assign w_commit_wr  = (r_state == ST_COMMIT) & w_frame_ok & w_rw & w_addr_ok;
    assign w_commit_err = (r_state == ST_COMMIT) & (~w_frame_ok | (w_rw & ~w_addr_ok));

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_rd_addr == ADDR_W'(i)) w_rd_data = r_regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_rd_active <= 1'b0;
            r_cipo      <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_cnt   <= '0;
                r_shift_in  <= '0;
                r_shift_out <= '0;
                r_rd_active <= 1'b0;
            end else if (w_bit) begin
                r_shift_in <= w_shift_nxt;
                if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_rd_load) begin
                    r_shift_out <= w_rd_data;
                    r_rd_active <= 1'b1;
                end
            end else if (w_out) begin
                r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
            end

            if (w_out)            r_cipo <= r_shift_out[DATA_W-1];
            else if (!w_in_frame) r_cipo <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_strobe <= w_commit_wr;
            r_frame_err <= w_commit_err;
            if (w_commit_wr) r_wr_addr <= w_addr;
            for (int i = 0; i < NUM_REGS; i++)
                if (w_commit_wr && (w_addr == ADDR_W'(i))) r_regs[i] <= w_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign CIPO      = r_cipo;
    assign cipo_oe   = ~r_ncs_sync[SYNC_FLOPS-1];
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: directed frame table, reset-mid-frame sequence,
// and random frames against a frame-level register model.
module tb_spi_regfile_periph;

  localparam int NR   = 5;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n, SCLK, COPI, nCS;
  logic        CIPO, cipo_oe, wr_strobe, frame_err;
  logic [39:0] regs_flat;
  logic [6:0]  wr_addr;

  spi_regfile_periph #(.SYNC_FLOPS(2), .ADDR_W(7), .DATA_W(8), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int n_strobe = 0, n_err = 0;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_strobe++;
    if (frame_err === 1'b1) n_err++;
  end

  // frame-level model
  logic [7:0] m_regs [NR];
  logic [6:0] m_wr_addr;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    int         nbits;
    int         exp_s;
    int         exp_e;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [39:0] m_flat();
    logic [39:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_wr_addr = 7'd0;
  endtask

  task automatic m_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                         input int nbits, output int es, output int ee, output logic [7:0] erd);
    es  = 0;
    ee  = 0;
    erd = (addr < NR) ? m_regs[addr] : 8'h00;
    if (nbits != 16) ee = 1;
    else if (rw) begin
      if (addr < NR) begin
        m_regs[addr] = data;
        m_wr_addr    = addr;
        es           = 1;
      end else ee = 1;
    end
  endtask

  task automatic send_bit(input logic b, output logic cipo_smp, output logic oe_smp);
    COPI = b;
    repeat (HALF) @(negedge clk);
    cipo_smp = CIPO;
    oe_smp   = cipo_oe;
    SCLK = 1'b1;
    repeat (HALF) @(negedge clk);
    SCLK = 1'b0;
  endtask

  task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                           input int nbits, output logic [7:0] rd, output int ds, output int de,
                           output logic addr_zero, output logic oe_ok);
    logic [15:0] w;
    logic        c, o;
    int          s0, e0;
    w = {rw, addr, data};
    s0 = n_strobe; e0 = n_err;
    rd = 8'h00; addr_zero = 1'b1; oe_ok = 1'b1;
    @(negedge clk);
    nCS = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      send_bit((b < 16) ? w[15-b] : 1'b0, c, o);
      if (b < 8 && c !== 1'b0) addr_zero = 1'b0;
      if (b >= 8 && b < 16) rd = {rd[6:0], c};
      if (o !== 1'b1) oe_ok = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    nCS = 1'b1;
    repeat (10) @(negedge clk);
    ds = n_strobe - s0;
    de = n_err - e0;
  endtask

  task automatic frame_and_check(input string tag, input logic rw, input logic [6:0] addr,
                                 input logic [7:0] data, input int nbits,
                                 input int xs, input int xe, input logic [7:0] xrd);
    logic [7:0] rd;
    int         ds, de;
    logic       az, ok;
    run_frame(rw, addr, data, nbits, rd, ds, de, az, ok);
    check({tag, " strobes"}, 64'(ds), 64'(xs));
    check({tag, " errs"}, 64'(de), 64'(xe));
    check({tag, " regs"}, 64'(regs_flat), 64'(m_flat()));
    check({tag, " wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
    check({tag, " cipo addr phase"}, 64'(az), 64'(1));
    check({tag, " oe idle"}, 64'(cipo_oe), 64'(0));
    if (nbits > 0) check({tag, " oe in frame"}, 64'(ok), 64'(1));
    if (!rw && nbits == 16) check({tag, " read data"}, 64'(rd), 64'(xrd));
  endtask

  initial begin
    int         es, ee;
    logic [7:0] erd;
    logic       c, o;
    logic [15:0] w;

    rst_n = 1'b0; SCLK = 1'b0; COPI = 1'b0; nCS = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    check("reset regs", 64'(regs_flat), 64'(0));
    check("reset CIPO", 64'(CIPO), 64'(0));
    check("reset oe", 64'(cipo_oe), 64'(0));
    check("reset strobe", 64'(wr_strobe), 64'(0));
    check("reset wr_addr", 64'(wr_addr), 64'(0));
    check("reset err", 64'(frame_err), 64'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    tbl[0] = '{1'b1, 7'd0,    8'hA5, 16, 1, 0, 8'h00};
    tbl[1] = '{1'b1, 7'd2,    8'h3C, 16, 1, 0, 8'h00};
    tbl[2] = '{1'b0, 7'd2,    8'h00, 16, 0, 0, 8'h3C};
    tbl[3] = '{1'b1, 7'd1,    8'h77, 10, 0, 1, 8'h00};
    tbl[4] = '{1'b1, 7'd1,    8'h77, 16, 1, 0, 8'h00};
    tbl[5] = '{1'b1, 7'h10,   8'hFF, 16, 0, 1, 8'h00};
    tbl[6] = '{1'b0, 7'h10,   8'h00, 16, 0, 0, 8'h00};
    tbl[7] = '{1'b1, 7'd1,    8'h11, 20, 0, 1, 8'h00};
    tbl[8] = '{1'b0, 7'd1,    8'h00, 16, 0, 0, 8'h77};
    tbl[9] = '{1'b0, 7'd0,    8'h00, 16, 0, 0, 8'hA5};

    for (int i = 0; i < 10; i++) begin
      m_frame(tbl[i].rw, tbl[i].addr, tbl[i].data, tbl[i].nbits, es, ee, erd);
      frame_and_check($sformatf("vec%0d", i), tbl[i].rw, tbl[i].addr, tbl[i].data,
                      tbl[i].nbits, tbl[i].exp_s, tbl[i].exp_e, tbl[i].exp_rd);
      if (i == 0) check("vec0 only reg0", 64'(regs_flat), 64'(40'h00_0000_00A5));
    end

    // reset asserted 9 bits into a write to addr 3
    w = {1'b1, 7'd3, 8'h5A};
    @(negedge clk);
    nCS = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < 9; b++) send_bit(w[15-b], c, o);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();
    check("midrst regs", 64'(regs_flat), 64'(0));
    check("midrst CIPO", 64'(CIPO), 64'(0));
    check("midrst oe", 64'(cipo_oe), 64'(0));
    check("midrst strobe", 64'(wr_strobe), 64'(0));
    check("midrst wr_addr", 64'(wr_addr), 64'(0));
    check("midrst err", 64'(frame_err), 64'(0));
    nCS = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_frame(1'b1, 7'd3, 8'h5A, 16, es, ee, erd);
    frame_and_check("post-rst write", 1'b1, 7'd3, 8'h5A, 16, es, ee, erd);
    check("post-rst reg3", 64'(regs_flat), 64'(40'h00_5A00_0000));

    for (int i = 0; i < 30; i++) begin
      logic       rw;
      logic [6:0] addr;
      logic [7:0] data;
      int         nb;
      rw   = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 6));
      data = 8'($urandom);
      nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      m_frame(rw, addr, data, nb, es, ee, erd);
      frame_and_check($sformatf("rnd%0d", i), rw, addr, data, nb, es, ee, erd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
